// File: rtl/spi_flash_pkg.sv
// Opcodes, phase lengths and state encoding shared by the SPI flash line fetcher.
package spi_flash_pkg;

  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;

  localparam int CMD_BITS   = 8;
  localparam int ADDR_BITS  = 24;
  localparam int DUMMY_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_END
  } state_e;

  function automatic int data_bits(input int line_size);
    return 8 * line_size;
  endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV clk cycles per half-period, held low while run_i is low.
module spi_sck_gen #(
  parameter int CLK_DIV = 1
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic run_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic          sck_q;
  logic          tc;

  assign tc     = (cnt_q == TC);
  assign rise_o = run_i & tc & ~sck_q;
  assign fall_o = run_i & tc & sck_q;
  assign sck_o  = sck_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || !run_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else if (tc) begin
      cnt_q <= '0;
      sck_q <= ~sck_q;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/spi_flash_line_fetch.sv
// Fetches one cache line from serial flash with a single SPI mode-0 read burst.
// Define SPI_FLF_FAST_READ_EN to use FAST READ (0x0B) with 8 dummy clocks.
module spi_flash_line_fetch
  import spi_flash_pkg::*;
#(
  parameter int LINE_SIZE = 16,
  parameter int CLK_DIV   = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   rd_i,
  input  logic [23:0]            addr_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [LINE_SIZE*8-1:0] line_o,
  output logic                   sck_o,
  output logic                   ce_n_o,
  output logic                   mosi_o,
  input  logic                   miso_i
);

  localparam int LW  = data_bits(LINE_SIZE);
  localparam int BCW = $clog2(LW);
  localparam logic [23:0] ALIGN_MASK = ~24'(LINE_SIZE - 1);

`ifdef SPI_FLF_FAST_READ_EN
  localparam logic [7:0] OPCODE     = OP_FAST_READ;
  localparam state_e     AFTER_ADDR = ST_DUMMY;
`else
  localparam logic [7:0] OPCODE     = OP_READ;
  localparam state_e     AFTER_ADDR = ST_DATA;
`endif

  // state | meaning: IDLE wait rd | CMD opcode | ADDR address | DUMMY fast-read pad | DATA shift in | END done pulse
  state_e         state_q;
  logic [BCW-1:0] cnt_q, cnt_d;
  logic [31:0]    tx_q;
  logic [LW-1:0]  line_q;
  logic           busy_q, done_q, ce_n_q, mosi_q, run_q;
  logic           rise, fall, last_bit;

  spi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .run_i  (run_q),
    .sck_o  (sck_o),
    .rise_o (rise),
    .fall_o (fall)
  );

  always_comb begin
    last_bit = 1'b0;
    case (state_q)
      ST_CMD:   last_bit = (cnt_q == BCW'(CMD_BITS - 1));
      ST_ADDR:  last_bit = (cnt_q == BCW'(ADDR_BITS - 1));
      ST_DUMMY: last_bit = (cnt_q == BCW'(DUMMY_BITS - 1));
      ST_DATA:  last_bit = &cnt_q;
      default:  last_bit = 1'b0;
    endcase
  end

  // The data phase uses the full counter range, so it wraps to zero on its own.
  assign cnt_d = last_bit ? '0 : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tx_q    <= '0;
      line_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ce_n_q  <= 1'b1;
      mosi_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE, ST_END: begin
          if (rd_i) begin
            state_q <= ST_CMD;
            cnt_q   <= '0;
            tx_q    <= {OPCODE[6:0], addr_i & ALIGN_MASK, 1'b0};
            mosi_q  <= OPCODE[7];
            ce_n_q  <= 1'b0;
            busy_q  <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          // SCK starts one cycle after CE falls, giving the first bit a longer setup.
          run_q <= 1'b1;
          if (rise && state_q == ST_DATA)
            line_q[cnt_q ^ BCW'(7)] <= miso_i;
          if (fall) begin
            cnt_q  <= cnt_d;
            mosi_q <= tx_q[31];
            tx_q   <= {tx_q[30:0], 1'b0};
            if (last_bit) begin
              case (state_q)
                ST_CMD:   state_q <= ST_ADDR;
                ST_ADDR:  state_q <= AFTER_ADDR;
                ST_DUMMY: state_q <= ST_DATA;
                default: begin
                  state_q <= ST_END;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  ce_n_q  <= 1'b1;
                  mosi_q  <= 1'b0;
                  run_q   <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign line_o = line_q;
  assign ce_n_o = ce_n_q;
  assign mosi_o = mosi_q;

endmodule

// File: tb/tb_spi_flash_line_fetch.sv
// Scoreboard bench for spi_flash_line_fetch with a behavioural serial-flash model.
module tb_spi_flash_line_fetch;

  localparam int unsigned LINE = 16;
  localparam int unsigned LW   = LINE * 8;
`ifdef SPI_FLF_FAST_READ_EN
  localparam int unsigned DIV   = 3;
  localparam logic [7:0]  OPC   = 8'h0B;
  localparam int unsigned DUMMY = 8;
`else
  localparam int unsigned DIV   = 1;
  localparam logic [7:0]  OPC   = 8'h03;
  localparam int unsigned DUMMY = 0;
`endif
  localparam int unsigned HDR   = 32 + DUMMY;
  localparam int unsigned NBITS = HDR + LW;
  localparam int unsigned LAT   = 2 * DIV * NBITS + 2;

  logic          clk = 1'b0, rst = 1'b1, rd = 1'b0, miso = 1'b0;
  logic [23:0]   addr = '0;
  logic          busy, done, sck, ce_n, mosi;
  logic [LW-1:0] line;

  spi_flash_line_fetch #(.LINE_SIZE(LINE), .CLK_DIV(DIV)) dut (
    .clk_i(clk), .rst_i(rst), .rd_i(rd), .addr_i(addr),
    .busy_o(busy), .done_o(done), .line_o(line),
    .sck_o(sck), .ce_n_o(ce_n), .mosi_o(mosi), .miso_i(miso)
  );

  always #5 clk = ~clk;

  int unsigned errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Flash contents: 0 = byte index within burst, 1 = all ones, 2 = address hash.
  function automatic logic [7:0] fbyte(input int unsigned mode, input logic [23:0] a,
                                       input int unsigned k);
    logic [23:0] x;
    x = a + 24'(k);
    case (mode)
      0:       return 8'(k);
      1:       return 8'hFF;
      default: return x[7:0] ^ x[15:8] ^ {x[22:16], x[23]} ^ 8'hA5;
    endcase
  endfunction

  function automatic logic [LW-1:0] exp_line(input int unsigned mode, input logic [23:0] a);
    logic [LW-1:0] v;
    for (int k = 0; k < int'(LINE); k++) v[8*k +: 8] = fbyte(mode, a, k);
    return v;
  endfunction

  int unsigned fl_mode = 0, fl_n = 0, fl_last_n = 0, fl_tail = 0, fl_last_tail = 0;
  int unsigned fl_bursts = 0, fl_idx = 0;
  logic [31:0] fl_hdr = '0, fl_last_hdr = '0;
  logic [7:0]  fl_byte;

  always @(posedge sck or posedge ce_n) begin
    if (ce_n === 1'b1) begin
      fl_last_n    = fl_n;
      fl_last_tail = fl_tail;
      fl_last_hdr  = fl_hdr;
      fl_n = 0; fl_tail = 0; fl_hdr = '0;
    end else begin
      if (fl_n < 32) fl_hdr = {fl_hdr[30:0], mosi};
      else if (mosi !== 1'b0) fl_tail++;
      fl_n++;
    end
  end

  always @(negedge sck or negedge ce_n) begin
    if (fl_mode == 1) miso = 1'b1;
    else if (fl_n >= HDR && fl_n < HDR + LW) begin
      fl_idx  = fl_n - HDR;
      fl_byte = fbyte(fl_mode, fl_hdr[23:0], fl_idx / 8);
      miso    = fl_byte[7 - (fl_idx % 8)];
    end else miso = 1'b0;
  end

  always @(negedge ce_n) fl_bursts++;

  typedef struct {
    logic [LW-1:0] ln;
    logic [31:0]   hdr;
    int unsigned   start;
  } exp_t;
  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned model_free = 0, n_done = 0, n_acc = 0;
  logic [LW-1:0] held_line = '0;

  task automatic issue(input logic [23:0] a);
    logic [23:0] al;
    exp_t e;
    rd = 1'b1; addr = a;
    if (cyc >= model_free) begin
      al = a & ~24'(LINE - 1);
      e.ln = exp_line(fl_mode, al); e.hdr = {OPC, al}; e.start = cyc;
      sb_q.push_back(e);
      model_free = cyc + LAT;
      n_acc++;
    end
    @(negedge clk);
    rd = 1'b0;
  endtask

  task automatic wait_drain();
    int unsigned n = 0;
    while (sb_q.size() != 0 && n < 4 * LAT) begin @(negedge clk); n++; end
    chk("drain", LW'(sb_q.size()), '0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_done();
    int unsigned n = 0;
    do begin @(negedge clk); n++; end while (done !== 1'b1 && n < 4 * LAT);
    chk("wait_done", LW'(done), LW'(1));
  endtask

  always @(posedge clk) if (rst) held_line = '0;

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      if (done === 1'b1) begin
        n_done++;
        if (sb_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=1 expected no pending fetch");
        end else begin
          mon_e = sb_q.pop_front();
          chk("line", line, mon_e.ln);
          chk("latency", LW'(cyc - mon_e.start), LW'(LAT));
          chk("header", LW'(fl_last_hdr), LW'(mon_e.hdr));
          chk("nbits", LW'(fl_last_n), LW'(NBITS));
          chk("mosi_tail", LW'(fl_last_tail), '0);
          chk("done_ce_n", LW'(ce_n), LW'(1));
          chk("done_busy", LW'(busy), '0);
          held_line = line;
        end
      end else if (busy === 1'b0) begin
        chk("line_held", line, held_line);
        chk("idle_ce_n", LW'(ce_n), LW'(1));
        chk("idle_sck", LW'(sck), '0);
      end
    end
  end

  initial begin
    #(64'd3000000);
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1);
  end

  int unsigned b0, d0;
  logic [LW-1:0] t1_line, ones;

  initial begin
    t1_line = 128'h0F0E0D0C0B0A09080706050403020100;
    ones    = '1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", LW'(busy), '0);
    chk("rst_done", LW'(done), '0);
    chk("rst_sck",  LW'(sck),  '0);
    chk("rst_ce_n", LW'(ce_n), LW'(1));
    chk("rst_mosi", LW'(mosi), '0);
    chk("rst_line", line, '0);
    rst = 1'b0;
    @(negedge clk);

    // single fetch, index-pattern flash
    fl_mode = 0;
    issue(24'h012345);
    wait_drain();
    chk("t1_line_literal", line, t1_line);

    // requests while busy are dropped
    fl_mode = 2;
    b0 = fl_bursts; d0 = n_done;
    issue(24'h00A5A0);
    repeat (4) @(negedge clk);  issue(24'h111111);
    repeat (44) @(negedge clk); issue(24'h222222);
    repeat (49) @(negedge clk); issue(24'h333333);
    wait_drain();
    chk("busy_rd_bursts", LW'(fl_bursts - b0), LW'(1));
    chk("busy_rd_dones",  LW'(n_done - d0),    LW'(1));

    // back-to-back: second request lands in the done cycle
    issue(24'h4567C0);
    wait_done();
    issue(24'hABCDE0);
    chk("b2b_ce_n_low", LW'(ce_n), '0);
    wait_drain();

    // reset in the middle of the data phase
    d0 = n_done;
    issue(24'h765430);
    repeat (2 * DIV * (HDR + 40)) @(negedge clk);
    rst = 1'b1;
    n_acc -= sb_q.size();
    sb_q.delete();
    model_free = 0;
    @(negedge clk);
    chk("abort_ce_n", LW'(ce_n), LW'(1));
    chk("abort_sck",  LW'(sck),  '0);
    chk("abort_busy", LW'(busy), '0);
    chk("abort_done", LW'(done), '0);
    rst = 1'b0;
    repeat (LAT + 20) @(negedge clk);
    chk("abort_no_done", LW'(n_done - d0), '0);
    issue(24'h0BEEF0);
    wait_drain();

    // top of address space, miso stuck high
    fl_mode = 1;
    issue(24'hFFFFF0);
    wait_drain();
    chk("stuck1_line", line, ones);
    chk("stuck1_idle", LW'(busy), '0);

    // random requests, many of them landing while busy
    fl_mode = 2;
    for (int r = 0; r < 14; r++) begin
      repeat ($urandom_range(0, LAT + 10)) @(negedge clk);
      issue(24'($urandom()));
    end
    wait_drain();
    chk("done_count", LW'(n_done), LW'(n_acc));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
